// File: rtl/mmcam_match_stage_pkg.sv
// Shared MMCAM_* field positions and default widths for the matching-memory stages.
package mmcam_match_stage_pkg;
  localparam int MMCAM_PKT_W   = 38;
  localparam int MMCAM_KEY_MSB = 37;
  localparam int MMCAM_KEY_LSB = 20;
  localparam int MMCAM_LR_BIT  = 19;
  localparam int MMCAM_MF_BIT  = 18;
  localparam int MMCAM_ENTRIES = 64;

  typedef enum logic [1:0] {
    OP_BYPASS = 2'd0,
    OP_WRITE  = 2'd1,
    OP_DELETE = 2'd2
  } mm_op_e;
endpackage

// File: rtl/mmcam_entry.sv
// One CAM entry: valid/key/LR registers and the pairing hit compare.
module mmcam_entry #(
  parameter int KEY_W = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set,
  input  logic             clr,
  input  logic [KEY_W-1:0] key_in,
  input  logic             lr_in,
  output logic             valid,
  output logic             hit
);
  logic [KEY_W-1:0] key_q;
  logic             lr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      key_q <= '0;
      lr_q  <= 1'b0;
    end else if (set) begin
      valid <= 1'b1;
      key_q <= key_in;
      lr_q  <= lr_in;
    end else if (clr) begin
      valid <= 1'b0;
    end
  end

  // only the opposite operand of the same key pairs
  assign hit = valid && (key_q == key_in) && (lr_q != lr_in);
endmodule

// File: rtl/mmcam_match_stage.sv
// Matching-memory CAM stage: pairs L/R operands by key, drives WR_E/DEL/ADDR to the data RAM.
// Optional MMCAM_OCC_CNT_EN adds OCC / OCC_PEAK occupancy counters.
module mmcam_match_stage
  import mmcam_match_stage_pkg::*;
#(
  parameter  int PKT_W   = MMCAM_PKT_W,
  parameter  int KEY_MSB = MMCAM_KEY_MSB,
  parameter  int KEY_LSB = MMCAM_KEY_LSB,
  parameter  int LR_BIT  = MMCAM_LR_BIT,
  parameter  int MF_BIT  = MMCAM_MF_BIT,
  parameter  int ENTRIES = MMCAM_ENTRIES,
  localparam int AW      = $clog2(ENTRIES)
) (
  input  logic             CP,
  input  logic             MR,
  input  logic [PKT_W-1:0] PACKET_IN,
  input  logic             Send_in,
  output logic             Ack_out,
  output logic [PKT_W-1:0] PACKET_OUT,
  output logic             Send_out,
  input  logic             Ack_in,
  output logic             WR_E,
  output logic             DEL,
  output logic [AW-1:0]    ADDR,
  output logic             FULL
`ifdef MMCAM_OCC_CNT_EN
  ,
  output logic [AW:0]      OCC,
  output logic [AW:0]      OCC_PEAK
`endif
);
  localparam int KEY_W = KEY_MSB - KEY_LSB + 1;

  logic [KEY_W-1:0]   key;
  logic               lr, mf;
  logic [ENTRIES-1:0] valid_vec, hit_vec, set_vec, clr_vec;
  logic               any_hit, accept, do_wr, do_del;
  logic [AW-1:0]      hit_idx, free_idx, op_addr;
  mm_op_e             op;

  assign key = PACKET_IN[KEY_MSB:KEY_LSB];
  assign lr  = PACKET_IN[LR_BIT];
  assign mf  = PACKET_IN[MF_BIT];

  // lowest-index priority: scan downwards so the last assignment wins
  always_comb begin
    any_hit  = 1'b0;
    hit_idx  = '0;
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        any_hit = 1'b1;
        hit_idx = AW'(i);
      end
      if (!valid_vec[i]) free_idx = AW'(i);
    end
  end

  always_comb begin
    op      = OP_BYPASS;
    op_addr = '0;
    if (mf) begin
      op      = any_hit ? OP_DELETE : OP_WRITE;
      op_addr = any_hit ? hit_idx : free_idx;
    end
  end

  assign FULL    = &valid_vec;
  // a miss with nowhere to go stalls; hits and bypasses always flow
  assign Ack_out = !MR && (!Send_out || Ack_in) && !(mf && !any_hit && FULL);
  assign accept  = Send_in && Ack_out;
  assign do_wr   = accept && (op == OP_WRITE);
  assign do_del  = accept && (op == OP_DELETE);

  for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
    assign set_vec[g] = do_wr  && (free_idx == AW'(g));
    assign clr_vec[g] = do_del && (hit_idx  == AW'(g));
    mmcam_entry #(.KEY_W(KEY_W)) u_entry (
      .clk    (CP),
      .rst    (MR),
      .set    (set_vec[g]),
      .clr    (clr_vec[g]),
      .key_in (key),
      .lr_in  (lr),
      .valid  (valid_vec[g]),
      .hit    (hit_vec[g])
    );
  end

  always_ff @(posedge CP or posedge MR) begin
    if (MR) begin
      PACKET_OUT <= '0;
      Send_out   <= 1'b0;
      WR_E       <= 1'b0;
      DEL        <= 1'b0;
      ADDR       <= '0;
    end else if (accept) begin
      PACKET_OUT <= PACKET_IN;
      Send_out   <= 1'b1;
      WR_E       <= (op == OP_WRITE);
      DEL        <= (op == OP_DELETE);
      ADDR       <= op_addr;
    end else if (Ack_in) begin
      Send_out   <= 1'b0;
    end
  end

`ifdef MMCAM_OCC_CNT_EN
  localparam logic [AW:0] OCC_ONE = (AW + 1)'(1);

  always_ff @(posedge CP or posedge MR) begin
    if (MR) begin
      OCC      <= '0;
      OCC_PEAK <= '0;
    end else begin
      if (do_wr)       OCC <= OCC + OCC_ONE;
      else if (do_del) OCC <= OCC - OCC_ONE;
      if (OCC > OCC_PEAK) OCC_PEAK <= OCC;
    end
  end
`endif
endmodule
